// File: rtl/sram_like_responder.sv
// Responder end of the SRAM-like req/addr_ok/data_ok interface. It holds a
// word-addressed memory, takes writes and reads when a request is accepted,
// and returns exactly one data_ok per accepted request, in order, no earlier
// than LAT cycles after the accept cycle.
//
// Handshake: a request transfers on any rising edge where req && addr_ok.
// addr_ok is combinational, does not look at req, and reflects only the
// registered occupancy and addr_stall (a same-cycle dequeue never frees a slot).
// A response transfers on any rising edge where data_ok is high. There is no
// back-pressure from the initiator, so the head entry leaves on that edge.
module sram_like_responder #(
  parameter int ADDR_W  = 12,
  parameter int MAX_OUT = 4,
  parameter int LAT     = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       req,
  input  logic                       wr,
  input  logic [1:0]                 size,
  input  logic [3:0]                 wstrb,
  input  logic [31:0]                addr,
  input  logic [31:0]                wdata,
  output logic                       addr_ok,
  output logic                       data_ok,
  output logic [31:0]                rdata,
  input  logic                       addr_stall,
  input  logic                       resp_stall,
  output logic [$clog2(MAX_OUT):0]   outstanding
);

  localparam int PW  = $clog2(MAX_OUT);
  localparam int CW  = PW + 1;
  localparam int AGW = $clog2(LAT + 1);

  // Backing store; intentionally not cleared by reset.
  logic [31:0]        mem [2**ADDR_W];

  // Response queue: control fields are reset, payload fields are not.
  logic [PW-1:0]      rd_ptr;
  logic [PW-1:0]      wr_ptr;
  logic [CW-1:0]      count;
  logic [MAX_OUT-1:0] q_valid;
  logic [MAX_OUT-1:0] q_wr;
  logic [31:0]        q_data [MAX_OUT];
  logic [AGW-1:0]     q_age  [MAX_OUT];

  logic [ADDR_W-1:0]  word_idx;
  logic               full;
  logic               accept;
  logic               head_ready;
  logic               unused_inputs;

  // size is informational and the upper/lower address bits simply alias.
  assign unused_inputs = ^{size, addr[31:ADDR_W+2], addr[1:0]};

  assign word_idx   = addr[ADDR_W+1:2];
  assign full       = (count == CW'(MAX_OUT));
  assign addr_ok    = !reset && !addr_stall && !full;
  assign accept     = req && addr_ok;
  assign head_ready = q_valid[rd_ptr] && (q_age[rd_ptr] == AGW'(LAT));
  assign data_ok    = !reset && head_ready && !resp_stall;
  assign rdata      = (data_ok && !q_wr[rd_ptr]) ? q_data[rd_ptr] : 32'h0;
  assign outstanding = count;

  // Byte-masked write into memory on an accepted write.
  always_ff @(posedge clk) begin
    if (accept && wr) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb[i]) mem[word_idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // Capture the response payload; reads sample the word at the accept edge.
  always_ff @(posedge clk) begin
    if (accept) begin
      q_wr[wr_ptr]   <= wr;
      q_data[wr_ptr] <= wr ? 32'h0 : mem[word_idx];
    end
  end

  // Queue pointers, valid bits, ages and occupancy count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      q_valid <= '0;
      for (int i = 0; i < MAX_OUT; i++) q_age[i] <= '0;
    end else begin
      for (int i = 0; i < MAX_OUT; i++) begin
        if (q_valid[i] && (q_age[i] != AGW'(LAT))) q_age[i] <= q_age[i] + AGW'(1);
      end
      if (data_ok) begin
        q_valid[rd_ptr] <= 1'b0;
        rd_ptr          <= rd_ptr + PW'(1);
      end
      if (accept) begin
        q_valid[wr_ptr] <= 1'b1;
        q_age[wr_ptr]   <= AGW'(1);
        wr_ptr          <= wr_ptr + PW'(1);
      end
      case ({accept, data_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_like_responder.sv
// Bench for sram_like_responder. A timestamp-based model (accept cycle + LAT,
// FIFO of pending responses, plain memory array) predicts all outputs every
// cycle; directed tests add literal expectations on top.
module tb_sram_like_responder;

  localparam int ADDR_W  = 12;
  localparam int MAX_OUT = 4;
  localparam int LAT     = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;
  logic        addr_stall;
  logic        resp_stall;
  logic [2:0]  outstanding;

  sram_like_responder #(.ADDR_W(ADDR_W), .MAX_OUT(MAX_OUT), .LAT(LAT)) dut (
    .clk(clk), .reset(reset), .req(req), .wr(wr), .size(size), .wstrb(wstrb),
    .addr(addr), .wdata(wdata), .addr_ok(addr_ok), .data_ok(data_ok),
    .rdata(rdata), .addr_stall(addr_stall), .resp_stall(resp_stall),
    .outstanding(outstanding)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic        wr;
    logic [31:0] data;
    int          rdy;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] m_mem [0:(2**ADDR_W)-1];
  logic [31:0] got_q[$];
  logic [31:0] got_cyc[$];
  logic [31:0] acc_cyc[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
  endtask

  function automatic logic [31:0] qat(input logic [31:0] q[$], input int i);
    return (i < q.size()) ? q[i] : 32'hxxxxxxxx;
  endfunction

  // ---------------- scoreboard / compare ----------------
  // Predicts every output each cycle, then advances the model as the
  // coming rising edge will.
  always @(negedge clk) begin : compare
    logic        e_aok;
    logic        e_dok;
    logic [31:0] e_rd;
    logic [ADDR_W-1:0] m_idx;
    exp_t        e;
    if (reset) begin
      check("rst_addr_ok", 32'(addr_ok), 32'h0);
      check("rst_data_ok", 32'(data_ok), 32'h0);
      check("rst_rdata", rdata, 32'h0);
      check("rst_outstanding", 32'(outstanding), 32'h0);
      exp_q.delete();
    end else begin
      e_aok = !addr_stall && (exp_q.size() < MAX_OUT);
      e_dok = (exp_q.size() > 0) && !resp_stall && (cyc >= exp_q[0].rdy);
      e_rd  = (e_dok && !exp_q[0].wr) ? exp_q[0].data : 32'h0;
      check("addr_ok", 32'(addr_ok), 32'(e_aok));
      check("data_ok", 32'(data_ok), 32'(e_dok));
      check("rdata", rdata, e_rd);
      check("outstanding", 32'(outstanding), 32'(exp_q.size()));
      if (data_ok) begin
        got_q.push_back(rdata);
        got_cyc.push_back(32'(cyc));
      end
      if (req && addr_ok) acc_cyc.push_back(32'(cyc));
      if (e_dok) void'(exp_q.pop_front());
      if (req && e_aok) begin
        m_idx = addr[ADDR_W+1:2];
        if (wr) begin
          for (int i = 0; i < 4; i++)
            if (wstrb[i]) m_mem[m_idx][8*i +: 8] = wdata[8*i +: 8];
        end
        e.wr   = wr;
        e.data = wr ? 32'h0 : m_mem[m_idx];
        e.rdy  = cyc + LAT;
        exp_q.push_back(e);
      end
    end
    cyc++;
  end

  // ---------------- driver tasks ----------------
  task automatic idle();
    req   = 1'b0;
    wr    = 1'b0;
    wstrb = 4'h0;
  endtask

  // Holds a request until accepted; returns #1 after the accepting edge.
  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s);
    int   n;
    logic acc;
    n = 0;
    req = 1'b1; wr = w; addr = a; wdata = d; wstrb = s; size = 2'd2;
    do begin
      @(negedge clk); #1;
      acc = addr_ok;
      @(posedge clk); #1;
      n++;
    end while (!acc && n < 60);
    if (!acc) fail_now("issue_accept");
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (outstanding != 3'd0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (outstanding != 3'd0) fail_now("drain");
    @(posedge clk); #1;
  endtask

  task automatic clear_logs();
    got_q.delete();
    got_cyc.delete();
    acc_cyc.delete();
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- directed tests ----------------
  logic done;

  initial begin
    reset = 1'b1; req = 1'b0; wr = 1'b0; size = 2'd0; wstrb = 4'h0;
    addr = 32'h0; wdata = 32'h0; addr_stall = 1'b0; resp_stall = 1'b0;
    done = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("init_outstanding", 32'(outstanding), 32'h0);
    check("init_addr_ok", 32'(addr_ok), 32'h0);
    reset = 1'b0;
    @(negedge clk); #1;
    check("post_rst_addr_ok", 32'(addr_ok), 32'h1);
    @(posedge clk); #1;

    // Write then read, back to back.
    clear_logs();
    issue(1'b1, 32'h1c0, 32'hDEADBEEF, 4'hF);
    issue(1'b0, 32'h1c0, 32'h0, 4'h0);
    idle();
    drain();
    check("t1_acc_b2b", qat(acc_cyc, 1), qat(acc_cyc, 0) + 32'd1);
    check("t1_wr_resp_cyc", qat(got_cyc, 0), qat(acc_cyc, 0) + 32'd2);
    check("t1_rd_resp_cyc", qat(got_cyc, 1), qat(acc_cyc, 0) + 32'd3);
    check("t1_wr_rdata", qat(got_q, 0), 32'h0);
    check("t1_rd_rdata", qat(got_q, 1), 32'hDEADBEEF);

    // Byte strobes.
    clear_logs();
    issue(1'b1, 32'h200, 32'h11223344, 4'hF);
    issue(1'b1, 32'h200, 32'hAABBCCDD, 4'b0101);
    issue(1'b0, 32'h200, 32'h0, 4'h0);
    idle();
    drain();
    check("t2_count", 32'(got_q.size()), 32'd3);
    check("t2_rdata", qat(got_q, 2), 32'h11BB33DD);

    // Preload words 0..9 with their index.
    for (int i = 0; i < 10; i++) issue(1'b1, 32'(i * 4), 32'(i), 4'hF);
    idle();
    drain();

    // Full queue under resp_stall.
    clear_logs();
    resp_stall = 1'b1;
    fork
      begin
        for (int i = 0; i < 5; i++) issue(1'b0, 32'(i * 4), 32'h0, 4'h0);
        idle();
      end
      begin
        repeat (8) @(posedge clk);
        #2;
        check("t3_outstanding_full", 32'(outstanding), 32'd4);
        check("t3_addr_ok_full", 32'(addr_ok), 32'h0);
        check("t3_accepts_held", 32'(acc_cyc.size()), 32'd4);
        resp_stall = 1'b0;
      end
    join
    drain();
    check("t3_count", 32'(got_q.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      check("t3_rdata", qat(got_q, i), 32'(i));
      check("t3_resp_b2b", qat(got_cyc, i), qat(got_cyc, 0) + 32'(i));
    end
    check("t3_fifth_accept", qat(acc_cyc, 4), qat(got_cyc, 0) + 32'd1);

    // Pointer wrap with random addr_stall.
    clear_logs();
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 10; i++) issue(1'b0, 32'(i * 4), 32'h0, 4'h0);
        idle();
        done = 1'b1;
      end
      begin
        while (!done) begin
          addr_stall = 1'($urandom_range(0, 1));
          @(posedge clk); #1;
        end
        addr_stall = 1'b0;
      end
    join
    drain();
    check("t4_count", 32'(got_q.size()), 32'd10);
    for (int i = 0; i < 10; i++) check("t4_rdata", qat(got_q, i), 32'(i));

    // Streaming: one accept and one response per cycle.
    clear_logs();
    fork
      begin
        for (int i = 0; i < 8; i++) issue(1'b0, 32'(i * 4), 32'h0, 4'h0);
        idle();
      end
      begin
        int n;
        n = 0;
        @(negedge clk); #1;
        while (!data_ok && n < 20) begin
          @(negedge clk); #1;
          n++;
        end
        for (int k = 0; k < 6; k++) begin
          check("t5_outstanding", 32'(outstanding), 32'(LAT));
          check("t5_data_ok", 32'(data_ok), 32'h1);
          @(negedge clk); #1;
        end
      end
    join
    drain();
    check("t5_count", 32'(got_q.size()), 32'd8);
    for (int i = 0; i < 8; i++) check("t5_rdata", qat(got_q, i), 32'(i));

    // Reset with responses outstanding.
    clear_logs();
    resp_stall = 1'b1;
    for (int i = 0; i < 3; i++) issue(1'b0, 32'(i * 4), 32'h0, 4'h0);
    idle();
    check("t6_outstanding_pre", 32'(outstanding), 32'd3);
    reset = 1'b1;
    #1;
    check("t6_rst_outstanding", 32'(outstanding), 32'h0);
    check("t6_rst_data_ok", 32'(data_ok), 32'h0);
    check("t6_rst_addr_ok", 32'(addr_ok), 32'h0);
    resp_stall = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk); #1;
    check("t6_rel_addr_ok", 32'(addr_ok), 32'h1);
    check("t6_rel_outstanding", 32'(outstanding), 32'h0);
    for (int k = 0; k < 5; k++) begin
      check("t6_no_stale_data_ok", 32'(data_ok), 32'h0);
      @(negedge clk); #1;
    end
    check("t6_no_responses", 32'(got_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sram_like_responder.md
Name: sram_like_responder

Overview:
- Responder (slave) end of the SRAM-like req/addr_ok/data_ok interface that the CPU core drives for instruction and data fetch.
- Accepts requests, performs writes and reads against an internal word-addressed memory, and returns one data_ok per accepted request, strictly in order, after a configurable latency.
- Used as the memory model behind inst_sram_* / data_sram_* in core-level benches.
- Provides stall hooks so the core's handshake corner cases can be exercised.

Parameters:
- ADDR_W, 12, word-index bits; memory depth is 2^ADDR_W 32-bit words.
- MAX_OUT, 4, maximum outstanding (accepted, not yet responded) requests. Must be a power of two and ≥ 2.
- LAT, 2, minimum cycles from the accept cycle to data_ok. Must be ≥ 1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  1  request valid from the initiator.
- wr  in  1  1 = write, 0 = read.
- size  in  2  0 = byte, 1 = half, 2 = word. Informational only; wstrb is authoritative.
- wstrb  in  4  byte write enables for writes.
- addr  in  32  byte address.
- wdata  in  32  write data.
- addr_ok  out  1  request accepted this cycle when req is also high.
- data_ok  out  1  head response valid this cycle.
- rdata  out  32  read data for the head response; 0 for write responses.
- addr_stall  in  1  test hook; forces addr_ok = 0.
- resp_stall  in  1  test hook; forces data_ok = 0.
- outstanding  out  $clog2(MAX_OUT)+1  current number of outstanding entries.

Behaviour:
- **Accept condition**
  - addr_ok = !addr_stall && (outstanding < MAX_OUT). It is combinational and independent of req.
  - A dequeue in the same cycle does not free a slot for that cycle (no bypass).
  - Accept = req && addr_ok.
- **Address decode**
  - Word index = addr[ADDR_W+1:2].
  - addr[31:ADDR_W+2] and addr[1:0] are ignored. Out-of-range addresses alias.
- **Write on accept:** at the accept-cycle edge, each byte i of mem[index] with wstrb[i] = 1 takes wdata[8i+7:8i]. wstrb = 0 writes nothing, but the request still gets a response.
- **Read on accept:** the full word mem[index] is sampled at the accept-cycle edge and stored in the queue entry. A read accepted after a write sees that write, including a write accepted in the immediately preceding cycle.
- **Response queue**
  - Circular FIFO of MAX_OUT entries. Each entry holds {wr, data[31:0], age}.
  - Read and write pointers wrap modulo MAX_OUT.
  - An entry is enqueued at the accept edge with age = 1.
  - Age increments on every edge while the entry is queued, saturating at LAT. If LAT = 1 the entry is enqueued already at LAT.
- **Response issue**
  - data_ok = head valid && head.age == LAT && !resp_stall. It is combinational from registered state.
  - rdata = head.data when data_ok && !head.wr, else 0.
  - On a data_ok cycle the head is dequeued at the edge.
  - Earliest data_ok is the cycle T+LAT for an accept in cycle T.
  - One response per cycle maximum. Back-to-back accepts yield back-to-back data_ok.
- **Counter**
  - Enqueue only: outstanding +1. Dequeue only: −1. Both in the same cycle: unchanged.
  - outstanding never exceeds MAX_OUT and never goes below 0.
- **Stalls**
  - Raising resp_stall holds the head entry and its data unchanged; ages continue to saturate.
  - Raising addr_stall does not affect queued entries.
- **Reset**
  - Outputs while reset is asserted: addr_ok = 0, data_ok = 0, rdata = 0, outstanding = 0.
  - Queue pointers, valid bits and ages are cleared.
  - Memory contents are not reset.
  - Reset asserted mid-operation discards all outstanding responses; none are returned after deassertion.
  - addr_ok may assert in the first cycle after deassertion.
- **Protocol:** the initiator is responsible for keeping addr/wdata stable while req is high and not yet accepted. The responder does not check or report protocol violations.

Test Plan:
- **Write then read, LAT = 2:** write addr 0x1c0, wdata 0xDEADBEEF, wstrb 0xF, accepted in cycle 0. Read 0x1c0 accepted in cycle 1. Required: data_ok in cycles 2 and 3; rdata = 0 in cycle 2 and 0xDEADBEEF in cycle 3.
- **Byte strobes:** mem word 0x11223344; write wstrb 0b0101 with wdata 0xAABBCCDD. A following read returns 0x11BB33DD.
- **Full queue, MAX_OUT = 4:** hold resp_stall = 1 and issue 5 reads back-to-back. Required: 4 accepts, outstanding = 4, addr_ok = 0 on the 5th. Drop resp_stall: four consecutive data_ok in order; the 5th request is accepted the cycle after outstanding falls to 3.
- **Pointer wrap:** 10 sequential reads of addresses 0x0–0x24 pre-loaded with the values 0–9, with random addr_stall. Required: data_ok values 0..9 in order, with no gaps or duplicates.
- **Simultaneous enqueue and dequeue:** steady streaming of one accept and one data_ok per cycle. Required: outstanding holds constant at LAT.
- **Reset mid-operation:** 3 reads outstanding, then assert reset for 1 cycle. Required: data_ok = 0 and outstanding = 0 immediately and afterwards, and addr_ok = 1 in the first cycle after release.
